// File: rtl/regfile_op_sequencer_pkg.sv
// Shared opcodes, state encoding and default widths for the register-file
// operation sequencer and its helpers.
package regfile_op_sequencer_pkg;

  localparam int DATA_W_DEF  = 8;
  localparam int ADDR_W_DEF  = 4;
  localparam int TIMEOUT_DEF = 16;

  localparam logic [2:0] OP_NOP   = 3'b000;
  localparam logic [2:0] OP_LOADI = 3'b001;
  localparam logic [2:0] OP_MOVE  = 3'b010;
  localparam logic [2:0] OP_ADD   = 3'b011;
  localparam logic [2:0] OP_SUB   = 3'b100;
  localparam logic [2:0] OP_AND   = 3'b101;
  localparam logic [2:0] OP_OR    = 3'b110;
  localparam logic [2:0] OP_XOR   = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_READ   = 3'd1,
    ST_EXEC   = 3'd2,
    ST_WRITE  = 3'd3,
    ST_FINISH = 3'd4
  } seqState_e;

  // MOVE and every ALU opcode need a register-file read cycle
  function automatic logic needsRead(input logic [2:0] op);
    return (op >= OP_MOVE);
  endfunction

  // Opcodes from ADD upward are handed to the external ALU
  function automatic logic isAluOp(input logic [2:0] op);
    return (op >= OP_ADD);
  endfunction

endpackage

// File: rtl/regfile_op_sequencer_if.sv
// Bundles the command, register-file and ALU signals seen by the sequencer.
// The master modport is the sequencer; the slave modport is its environment
// (instruction source, register file and ALU).
interface regfile_op_sequencer_if
  import regfile_op_sequencer_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) ();

  logic              cmdValid;
  logic              cmdReady;
  logic [2:0]        cmdOp;
  logic [ADDR_W-1:0] cmdDst;
  logic [ADDR_W-1:0] cmdSrcA;
  logic [ADDR_W-1:0] cmdSrcB;
  logic [DATA_W-1:0] cmdImm;

  logic [ADDR_W-1:0] A_sel;
  logic [ADDR_W-1:0] B_sel;
  logic [DATA_W-1:0] A;
  logic [DATA_W-1:0] B;

  logic              aluStart;
  logic [2:0]        aluOp;
  logic [DATA_W-1:0] aluOpA;
  logic [DATA_W-1:0] aluOpB;
  logic              aluDone;
  logic [DATA_W-1:0] aluResult;

  logic              replaceEn;
  logic [ADDR_W-1:0] replaceSel;
  logic [DATA_W-1:0] replaceData;

  logic              opDone;
  logic              opError;

  modport master (
    input  cmdValid, cmdOp, cmdDst, cmdSrcA, cmdSrcB, cmdImm,
    input  A, B, aluDone, aluResult,
    output cmdReady, A_sel, B_sel,
    output aluStart, aluOp, aluOpA, aluOpB,
    output replaceEn, replaceSel, replaceData,
    output opDone, opError
  );

  modport slave (
    output cmdValid, cmdOp, cmdDst, cmdSrcA, cmdSrcB, cmdImm,
    output A, B, aluDone, aluResult,
    input  cmdReady, A_sel, B_sel,
    input  aluStart, aluOp, aluOpA, aluOpB,
    input  replaceEn, replaceSel, replaceData,
    input  opDone, opError
  );

endinterface

// File: rtl/regfile_op_sequencer_timeout.sv
// Counts EXEC cycles spent waiting for the ALU. expired_o is high in the
// cycle whose missing aluDone would make the wait reach TIMEOUT cycles.
module regfile_op_timeout #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Clear has priority; the count saturates so it can never wrap
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i && (count_q != CNT_W'(TIMEOUT))) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  // Counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired_o = (count_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/regfile_op_sequencer.sv
// Sequences one register-file operation at a time: accepts a command, reads
// the sources, runs the external ALU when needed and writes the result back.
module regfile_op_sequencer
  import regfile_op_sequencer_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input logic                   clk,
  input logic                   rst_n,
  regfile_op_sequencer_if.master bus
);

  seqState_e state_q;
  seqState_e state_d;

  logic              accept;
  logic              cmdReady;
  logic              replaceEn;
  logic              opDone;
  logic              opError;

  logic [2:0]        op_q;
  logic [ADDR_W-1:0] dst_q;
  logic [ADDR_W-1:0] aSel_q;
  logic [ADDR_W-1:0] bSel_q;
  logic [DATA_W-1:0] aluOpA_q;
  logic [DATA_W-1:0] aluOpB_q;
  logic              aluStart_q;
  logic [ADDR_W-1:0] replaceSel_q;
  logic [DATA_W-1:0] replaceData_q;

  logic              toClear;
  logic              toEnable;
  logic              toExpired;

  // The wait counter only runs while EXEC is waiting on aluDone
  assign toClear  = (state_q != ST_EXEC);
  assign toEnable = (state_q == ST_EXEC) && !bus.aluDone;

  regfile_op_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear_i   (toClear),
    .enable_i  (toEnable),
    .expired_o (toExpired)
  );

  // Next-state and strobe decode; a late aluDone beats the timeout
  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    cmdReady  = 1'b0;
    replaceEn = 1'b0;
    opDone    = 1'b0;
    opError   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cmdReady = 1'b1;
        if (bus.cmdValid) begin
          accept = 1'b1;
          if (bus.cmdOp == OP_NOP) begin
            state_d = ST_FINISH;
          end else if (bus.cmdOp == OP_LOADI) begin
            state_d = ST_WRITE;
          end else begin
            state_d = ST_READ;
          end
        end
      end
      ST_READ: begin
        state_d = isAluOp(op_q) ? ST_EXEC : ST_WRITE;
      end
      ST_EXEC: begin
        if (bus.aluDone) begin
          state_d = ST_WRITE;
        end else if (toExpired) begin
          opError = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_WRITE: begin
        replaceEn = 1'b1;
        opDone    = 1'b1;
        state_d   = ST_IDLE;
      end
      ST_FINISH: begin
        opDone  = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Command latches, operand capture and write-back staging; the write
  // port registers are loaded on the edge entering WRITE and then hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q          <= '0;
      dst_q         <= '0;
      aSel_q        <= '0;
      bSel_q        <= '0;
      aluOpA_q      <= '0;
      aluOpB_q      <= '0;
      aluStart_q    <= 1'b0;
      replaceSel_q  <= '0;
      replaceData_q <= '0;
    end else begin
      aluStart_q <= 1'b0;
      if (accept) begin
        op_q  <= bus.cmdOp;
        dst_q <= bus.cmdDst;
        if (needsRead(bus.cmdOp)) begin
          aSel_q <= bus.cmdSrcA;
          bSel_q <= bus.cmdSrcB;
        end
        if (bus.cmdOp == OP_LOADI) begin
          replaceSel_q  <= bus.cmdDst;
          replaceData_q <= bus.cmdImm;
        end
      end
      if (state_q == ST_READ) begin
        aluOpA_q <= bus.A;
        aluOpB_q <= bus.B;
        if (isAluOp(op_q)) begin
          aluStart_q <= 1'b1;
        end else begin
          replaceSel_q  <= dst_q;
          replaceData_q <= bus.A;
        end
      end
      if ((state_q == ST_EXEC) && bus.aluDone) begin
        replaceSel_q  <= dst_q;
        replaceData_q <= bus.aluResult;
      end
    end
  end

  assign bus.cmdReady    = cmdReady;
  assign bus.A_sel       = aSel_q;
  assign bus.B_sel       = bSel_q;
  assign bus.aluStart    = aluStart_q;
  assign bus.aluOp       = op_q;
  assign bus.aluOpA      = aluOpA_q;
  assign bus.aluOpB      = aluOpB_q;
  assign bus.replaceEn   = replaceEn;
  assign bus.replaceSel  = replaceSel_q;
  assign bus.replaceData = replaceData_q;
  assign bus.opDone      = opDone;
  assign bus.opError     = opError;

endmodule

// File: tb/tb_regfile_op_sequencer.sv
// Bench for regfile_op_sequencer with a register-file model and an ALU model
// whose response delay is set per operation.
module tb_regfile_op_sequencer;
  import regfile_op_sequencer_pkg::*;

  typedef struct {
    logic [2:0] op;
    logic [3:0] dst;
    logic [3:0] srcA;
    logic [3:0] srcB;
    logic [7:0] imm;
    int         delay;
    int         expEnd;
    bit         expErr;
    bit         expWrite;
    logic [7:0] expData;
    bit         expStart;
    logic [7:0] expOpA;
    logic [7:0] expOpB;
  } vec_t;

  logic clk;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;
  int   aluDelay = -1;
  int   aluWait  = 0;
  bit   aluPending = 1'b0;
  logic [7:0] regs [16];
  vec_t vecs [11];
  logic [2:0] sOp  [6];
  logic [3:0] sDst [6];
  logic [3:0] sSrc [6];
  logic [7:0] sImm [6];

  regfile_op_sequencer_if #(.DATA_W(8), .ADDR_W(4)) bus ();

  regfile_op_sequencer #(
    .DATA_W  (8),
    .ADDR_W  (4),
    .TIMEOUT (16)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  assign bus.A = regs[bus.A_sel];
  assign bus.B = regs[bus.B_sel];

  // Register file write port
  always @(posedge clk) begin
    if (bus.replaceEn) regs[bus.replaceSel] = bus.replaceData;
  end

  function automatic logic [7:0] aluModel(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      default: return 8'h00;
    endcase
  endfunction

  // ALU: answers aluDelay cycles after the aluStart cycle (never if negative)
  always @(negedge clk) begin
    if (!rst_n) begin
      aluPending    = 1'b0;
      bus.aluDone   = 1'b0;
      bus.aluResult = 8'h00;
    end else begin
      if (bus.aluDone) aluPending = 1'b0;
      if (bus.aluStart) begin
        aluPending    = 1'b1;
        aluWait       = 0;
        bus.aluResult = aluModel(bus.aluOp, bus.aluOpA, bus.aluOpB);
      end else if (aluPending) begin
        aluWait++;
      end
      bus.aluDone = aluPending && (aluWait == aluDelay);
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete, got running, expected finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Issues one command from an IDLE cycle (called at negedge+2) and follows
  // it to opDone/opError, returning at negedge+2 of the following IDLE cycle
  task automatic applyStimulus(input vec_t v, input string tag);
    int endCyc = 0;
    bit isErr = 1'b0;
    int writes = 0;
    int starts = 0;
    int busyReady = 0;
    int unstable = 0;
    int waitCnt = 0;
    logic [3:0] wSel = '0;
    logic [7:0] wData = '0;
    logic [7:0] opA = '0;
    logic [7:0] opB = '0;
    logic [3:0] aSelRead = '0;
    aluDelay     = v.delay;
    bus.cmdOp    = v.op;
    bus.cmdDst   = v.dst;
    bus.cmdSrcA  = v.srcA;
    bus.cmdSrcB  = v.srcB;
    bus.cmdImm   = v.imm;
    bus.cmdValid = 1'b1;
    while (!bus.cmdReady && waitCnt < 20) begin
      @(negedge clk);
      #2;
      waitCnt++;
    end
    checkOutput({tag, ".ready"}, 32'(bus.cmdReady), 32'd1);
    @(negedge clk);
    bus.cmdValid = 1'b0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      #2;
      if (bus.cmdReady) busyReady++;
      if (cyc == 1) aSelRead = bus.A_sel;
      if (bus.aluStart) begin
        starts++;
        opA = bus.aluOpA;
        opB = bus.aluOpB;
      end
      if (v.expStart && cyc >= 2 &&
          (bus.aluOpA !== v.expOpA || bus.aluOpB !== v.expOpB || bus.aluOp !== v.op)) unstable++;
      if (bus.replaceEn) begin
        writes++;
        wSel  = bus.replaceSel;
        wData = bus.replaceData;
      end
      if (bus.opDone || bus.opError) begin
        endCyc = cyc;
        isErr  = bus.opError;
        break;
      end
      @(negedge clk);
    end
    checkOutput({tag, ".endCycle"}, 32'(endCyc), 32'(v.expEnd));
    checkOutput({tag, ".opError"}, 32'(isErr), 32'(v.expErr));
    checkOutput({tag, ".writes"}, 32'(writes), 32'(v.expWrite));
    if (v.expWrite) begin
      checkOutput({tag, ".replaceSel"}, 32'(wSel), 32'(v.dst));
      checkOutput({tag, ".replaceData"}, 32'(wData), 32'(v.expData));
    end
    checkOutput({tag, ".aluStarts"}, 32'(starts), 32'(v.expStart));
    if (v.expStart) begin
      checkOutput({tag, ".aluOpA"}, 32'(opA), 32'(v.expOpA));
      checkOutput({tag, ".aluOpB"}, 32'(opB), 32'(v.expOpB));
      checkOutput({tag, ".operandsStable"}, 32'(unstable), 32'd0);
    end
    if (v.op >= OP_MOVE) checkOutput({tag, ".A_selInRead"}, 32'(aSelRead), 32'(v.srcA));
    checkOutput({tag, ".readyWhileBusy"}, 32'(busyReady), 32'd0);
    @(negedge clk);
    #2;
    checkOutput({tag, ".idleAfter"}, 32'(bus.cmdReady), 32'd1);
  endtask

  task automatic driveStream(input int i);
    bus.cmdOp   = sOp[i];
    bus.cmdDst  = sDst[i];
    bus.cmdSrcA = sSrc[i];
    bus.cmdSrcB = 4'd0;
    bus.cmdImm  = sImm[i];
  endtask

  initial begin
    int idx;
    int accepts;
    int dones;
    int writes;
    int nopWrites;
    int viol;
    int lastDone;
    int errs;
    int readyLow;
    bit prevAcc;
    logic [2:0] curOp;

    for (int i = 0; i < 16; i++) regs[i] = 8'h00;
    rst_n        = 1'b0;
    bus.cmdValid = 1'b0;
    bus.cmdOp    = 3'd0;
    bus.cmdDst   = 4'd0;
    bus.cmdSrcA  = 4'd0;
    bus.cmdSrcB  = 4'd0;
    bus.cmdImm   = 8'h00;

    //              op        dst    srcA   srcB   imm    dly end err wr  data   st  opA    opB
    vecs[0]  = '{OP_LOADI, 4'd3, 4'd0, 4'd0, 8'hAA,  0,  1, 0, 1, 8'hAA, 0, 8'h00, 8'h00};
    vecs[1]  = '{OP_LOADI, 4'd1, 4'd0, 4'd0, 8'h0F,  0,  1, 0, 1, 8'h0F, 0, 8'h00, 8'h00};
    vecs[2]  = '{OP_LOADI, 4'd2, 4'd0, 4'd0, 8'h01,  0,  1, 0, 1, 8'h01, 0, 8'h00, 8'h00};
    vecs[3]  = '{OP_ADD,   4'd4, 4'd1, 4'd2, 8'h00,  2,  5, 0, 1, 8'h10, 1, 8'h0F, 8'h01};
    vecs[4]  = '{OP_MOVE,  4'd5, 4'd4, 4'd0, 8'h00,  0,  2, 0, 1, 8'h10, 0, 8'h00, 8'h00};
    vecs[5]  = '{OP_SUB,   4'd6, 4'd1, 4'd2, 8'h00, -1, 17, 1, 0, 8'h00, 1, 8'h0F, 8'h01};
    vecs[6]  = '{OP_AND,   4'd7, 4'd1, 4'd2, 8'h00, 15, 18, 0, 1, 8'h01, 1, 8'h0F, 8'h01};
    vecs[7]  = '{OP_NOP,   4'd0, 4'd0, 4'd0, 8'h00,  0,  1, 0, 0, 8'h00, 0, 8'h00, 8'h00};
    vecs[8]  = '{OP_XOR,   4'd2, 4'd2, 4'd1, 8'h00,  0,  3, 0, 1, 8'h0E, 1, 8'h01, 8'h0F};
    vecs[9]  = '{OP_MOVE,  4'd1, 4'd1, 4'd0, 8'h00,  0,  2, 0, 1, 8'h0F, 0, 8'h00, 8'h00};
    vecs[10] = '{OP_OR,    4'd0, 4'd3, 4'd4, 8'h00,  1,  4, 0, 1, 8'hBA, 1, 8'hAA, 8'h10};

    sOp[0] = OP_NOP;   sDst[0] = 4'd0;  sSrc[0] = 4'd0;  sImm[0] = 8'h00;
    sOp[1] = OP_LOADI; sDst[1] = 4'd10; sSrc[1] = 4'd0;  sImm[1] = 8'h5A;
    sOp[2] = OP_MOVE;  sDst[2] = 4'd11; sSrc[2] = 4'd10; sImm[2] = 8'h00;
    sOp[3] = OP_NOP;   sDst[3] = 4'd0;  sSrc[3] = 4'd0;  sImm[3] = 8'h00;
    sOp[4] = OP_LOADI; sDst[4] = 4'd12; sSrc[4] = 4'd0;  sImm[4] = 8'hC3;
    sOp[5] = OP_MOVE;  sDst[5] = 4'd13; sSrc[5] = 4'd12; sImm[5] = 8'h00;

    // Reset values
    repeat (2) @(negedge clk);
    #2;
    checkOutput("reset.cmdReady", 32'(bus.cmdReady), 32'd1);
    checkOutput("reset.replaceEn", 32'(bus.replaceEn), 32'd0);
    checkOutput("reset.opDone", 32'(bus.opDone), 32'd0);
    checkOutput("reset.aluStart", 32'(bus.aluStart), 32'd0);
    checkOutput("reset.replaceData", 32'(bus.replaceData), 32'd0);
    checkOutput("reset.A_sel", 32'(bus.A_sel), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 11; i++) applyStimulus(vecs[i], $sformatf("v%0d", i));

    checkOutput("reg0", 32'(regs[0]), 32'h0000_00BA);
    checkOutput("reg1", 32'(regs[1]), 32'h0000_000F);
    checkOutput("reg2", 32'(regs[2]), 32'h0000_000E);
    checkOutput("reg3", 32'(regs[3]), 32'h0000_00AA);
    checkOutput("reg4", 32'(regs[4]), 32'h0000_0010);
    checkOutput("reg5", 32'(regs[5]), 32'h0000_0010);
    checkOutput("reg6", 32'(regs[6]), 32'h0000_0000);
    checkOutput("reg7", 32'(regs[7]), 32'h0000_0001);

    // cmdValid held high across a NOP/LOADI/MOVE mix
    idx = 0; accepts = 0; dones = 0; writes = 0; nopWrites = 0; viol = 0;
    lastDone = -1; prevAcc = 1'b0; curOp = OP_NOP;
    driveStream(0);
    bus.cmdValid = 1'b1;
    for (int c = 0; c < 30; c++) begin
      if (prevAcc && bus.cmdReady) viol++;
      if (bus.cmdReady && (bus.opDone || bus.replaceEn || bus.aluStart)) viol++;
      if (bus.replaceEn && curOp == OP_NOP) nopWrites++;
      if (bus.replaceEn) writes++;
      if (bus.opDone) begin
        dones++;
        lastDone = c;
      end
      prevAcc = bus.cmdValid && bus.cmdReady;
      if (prevAcc) begin
        accepts++;
        curOp = bus.cmdOp;
        idx++;
      end
      @(negedge clk);
      if (idx < 6) driveStream(idx);
      else bus.cmdValid = 1'b0;
      #2;
    end
    checkOutput("stream.accepts", 32'(accepts), 32'd6);
    checkOutput("stream.opDones", 32'(dones), 32'd6);
    checkOutput("stream.writes", 32'(writes), 32'd4);
    checkOutput("stream.nopWrites", 32'(nopWrites), 32'd0);
    checkOutput("stream.readyViolations", 32'(viol), 32'd0);
    checkOutput("stream.lastDoneCycle", 32'(lastDone), 32'd13);
    checkOutput("stream.reg11", 32'(regs[11]), 32'h0000_005A);
    checkOutput("stream.reg13", 32'(regs[13]), 32'h0000_00C3);

    // Reset while EXEC waits on the ALU
    aluDelay     = -1;
    bus.cmdOp    = OP_ADD;
    bus.cmdDst   = 4'd9;
    bus.cmdSrcA  = 4'd1;
    bus.cmdSrcB  = 4'd2;
    bus.cmdValid = 1'b1;
    checkOutput("rstMid.acceptReady", 32'(bus.cmdReady), 32'd1);
    @(negedge clk);
    bus.cmdValid = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    checkOutput("rstMid.opABefore", 32'(bus.aluOpA), 32'h0000_000F);
    #1;
    rst_n = 1'b0;
    bus.cmdValid = 1'b1;
    #1;
    checkOutput("rstMid.aluOpA", 32'(bus.aluOpA), 32'd0);
    checkOutput("rstMid.aluOpB", 32'(bus.aluOpB), 32'd0);
    checkOutput("rstMid.aluOp", 32'(bus.aluOp), 32'd0);
    checkOutput("rstMid.replaceSel", 32'(bus.replaceSel), 32'd0);
    checkOutput("rstMid.replaceData", 32'(bus.replaceData), 32'd0);
    checkOutput("rstMid.replaceEn", 32'(bus.replaceEn), 32'd0);
    checkOutput("rstMid.opDone", 32'(bus.opDone), 32'd0);
    checkOutput("rstMid.opError", 32'(bus.opError), 32'd0);
    checkOutput("rstMid.cmdReady", 32'(bus.cmdReady), 32'd1);
    repeat (3) @(negedge clk);
    bus.cmdValid = 1'b0;
    rst_n = 1'b1;
    dones = 0; writes = 0; errs = 0; readyLow = 0;
    for (int c = 0; c < 25; c++) begin
      #2;
      if (bus.opDone) dones++;
      if (bus.replaceEn) writes++;
      if (bus.opError) errs++;
      if (!bus.cmdReady) readyLow++;
      @(negedge clk);
    end
    checkOutput("rstMid.laterOpDone", 32'(dones), 32'd0);
    checkOutput("rstMid.laterWrites", 32'(writes), 32'd0);
    checkOutput("rstMid.laterErrors", 32'(errs), 32'd0);
    checkOutput("rstMid.readyLowCycles", 32'(readyLow), 32'd0);
    checkOutput("rstMid.reg9", 32'(regs[9]), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
